// File: rtl/spi_cmd_pkg.sv
// Shared encodings for the SPI command sequencer: commands, FSM states,
// frame-field offsets, STATUS word layout and the reserved-address window.
package spi_cmd_pkg;

  localparam int DEF_CMD_W  = 2;
  localparam int DEF_ADDR_W = 6;
  localparam int DEF_DATA_W = 12;

  typedef enum logic [1:0] {
    CMD_NOP    = 2'd0,
    CMD_WRITE  = 2'd1,
    CMD_READ   = 2'd2,
    CMD_STATUS = 2'd3
  } cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

  // STATUS data-field layout: {pad, ovr, timeout, ill, 0, frame_cnt[7:0]}
  localparam int ST_OVR_BIT = 11;
  localparam int ST_TMO_BIT = 10;
  localparam int ST_ILL_BIT = 9;
  localparam int ST_CNT_W   = 8;

  // The top RSV_SPAN addresses of the register space are reserved.
  localparam int RSV_SPAN = 4;

  function automatic int rsv_base(int addr_w);
    return (1 << addr_w) - RSV_SPAN;
  endfunction

  // Frame = {cmd, addr, data}, data at bit 0.
  function automatic int addr_lsb(int data_w);
    return data_w;
  endfunction

  function automatic int cmd_lsb(int addr_w, int data_w);
    return addr_w + data_w;
  endfunction

endpackage

// File: rtl/spi_cmd_ctrl_if.sv
// Register-bus handshake between the command sequencer (master) and the
// register file (slave).
interface spi_cmd_ctrl_if
  import spi_cmd_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);
  logic              BUS_REQ;
  logic              BUS_WE;
  logic [ADDR_W-1:0] BUS_ADDR;
  logic [DATA_W-1:0] BUS_WDATA;
  logic              BUS_ACK;
  logic [DATA_W-1:0] BUS_RDATA;

  modport master (
    output BUS_REQ, BUS_WE, BUS_ADDR, BUS_WDATA,
    input  BUS_ACK, BUS_RDATA
  );

  modport slave (
    input  BUS_REQ, BUS_WE, BUS_ADDR, BUS_WDATA,
    output BUS_ACK, BUS_RDATA
  );
endinterface

// File: rtl/spi_cmd_timeout.sv
// Loadable up-counter with synchronous clear; expired is high while the
// count equals lim.
module spi_cmd_timeout #(
  parameter int W = 8
) (
  input  logic         CLK_SYS,
  input  logic         RSTN,
  input  logic         clr,
  input  logic         ld,
  input  logic [W-1:0] ld_val,
  input  logic         en,
  input  logic [W-1:0] lim,
  output logic         expired
);
  logic [W-1:0] cnt;

  // NOTE: reset is sampled on the clock edge only (synchronous), so it is
  // not in the sensitivity list.
  always_ff @(posedge CLK_SYS) begin
    if (!RSTN)    cnt <= '0;
    else if (clr) cnt <= '0;
    else if (ld)  cnt <= ld_val;
    else if (en)  cnt <= cnt + 1'b1;
  end

  assign expired = (cnt == lim);
endmodule

// File: rtl/spi_cmd_ctrl.sv
// Decodes each completed SPI frame into a register-bus command, runs it with
// a timeout, and loads the response word shifted out on the next frame.
module spi_cmd_ctrl
  import spi_cmd_pkg::*;
#(
  parameter int          CMD_W   = DEF_CMD_W,
  parameter int          ADDR_W  = DEF_ADDR_W,
  parameter int          DATA_W  = DEF_DATA_W,
  parameter logic [7:0]  TIMEOUT = 8'd64,
  localparam int         FRAME_W = CMD_W + ADDR_W + DATA_W
) (
  input  logic               CLK_SYS,
  input  logic               RSTN,
  input  logic               SPI_DRDY,
  input  logic [FRAME_W-1:0] SPI_RX,
  output logic [FRAME_W-1:0] SPI_TX,
  output logic               BUSY,
  spi_cmd_ctrl_if.master     bus
);
  localparam int                ADDR_LSB = addr_lsb(DATA_W);
  localparam int                CMD_LSB  = cmd_lsb(ADDR_W, DATA_W);
  localparam logic [ADDR_W-1:0] RSV_BASE = ADDR_W'(rsv_base(ADDR_W));
  localparam logic [7:0]        TMO_LIM  = TIMEOUT - 8'd1;

  state_e               state_q, state_nxt;
  logic                 drdy_dly;
  logic [CMD_W-1:0]     cmd_q,   cmd_nxt;
  logic [ADDR_W-1:0]    addr_q,  addr_nxt;
  logic [DATA_W-1:0]    data_q,  data_nxt;
  logic [FRAME_W-1:0]   tx_q,    tx_nxt;
  logic                 req_q,   req_nxt;
  logic                 we_q,    we_nxt;
  logic [ST_CNT_W-1:0]  fcnt_q,  fcnt_nxt;
  logic                 ovr_q,   ovr_nxt;
  logic                 tmo_q,   tmo_nxt;
  logic                 ill_q,   ill_nxt;
  logic                 tmo_clr, tmo_en, tmo_exp;

  logic                 frame_evt;
  logic [CMD_W-1:0]     rx_cmd;
  logic [ADDR_W-1:0]    rx_addr;
  logic [DATA_W-1:0]    rx_data;
  logic [DATA_W-1:0]    st_data;

  assign frame_evt = SPI_DRDY & ~drdy_dly;
  assign rx_cmd    = SPI_RX[CMD_LSB +: CMD_W];
  assign rx_addr   = SPI_RX[ADDR_LSB +: ADDR_W];
  assign rx_data   = SPI_RX[DATA_W-1:0];

  spi_cmd_timeout #(.W(8)) u_timeout (
    .CLK_SYS (CLK_SYS),
    .RSTN    (RSTN),
    .clr     (tmo_clr),
    .ld      (1'b0),
    .ld_val  (8'd0),
    .en      (tmo_en),
    .lim     (TMO_LIM),
    .expired (tmo_exp)
  );

  // STATUS reports the frames accepted before the STATUS frame itself.
  always_comb begin
    st_data                 = '0;
    st_data[ST_OVR_BIT]     = ovr_q;
    st_data[ST_TMO_BIT]     = tmo_q;
    st_data[ST_ILL_BIT]     = ill_q;
    st_data[ST_CNT_W-1:0]   = fcnt_q;
  end

  // NOTE: every output of this block gets a default first so no path leaves
  // a variable unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state_q;
    cmd_nxt   = cmd_q;
    addr_nxt  = addr_q;
    data_nxt  = data_q;
    tx_nxt    = tx_q;
    req_nxt   = req_q;
    we_nxt    = we_q;
    fcnt_nxt  = fcnt_q;
    ovr_nxt   = ovr_q;
    tmo_nxt   = tmo_q;
    ill_nxt   = ill_q;
    tmo_clr   = 1'b0;
    tmo_en    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (frame_evt) begin
          cmd_nxt   = rx_cmd;
          addr_nxt  = rx_addr;
          data_nxt  = rx_data;
          fcnt_nxt  = fcnt_q + 8'd1;
          state_nxt = ST_RESP;
          case (rx_cmd)
            CMD_W'(CMD_STATUS): begin
              tx_nxt  = {rx_cmd, rx_addr, st_data};
              ovr_nxt = 1'b0;
              tmo_nxt = 1'b0;
              ill_nxt = 1'b0;
            end
            CMD_W'(CMD_WRITE), CMD_W'(CMD_READ): begin
              if (rx_addr >= RSV_BASE) begin
                ill_nxt = 1'b1;
                tx_nxt  = {rx_cmd, rx_addr, {DATA_W{1'b1}}};
              end else begin
                req_nxt   = 1'b1;
                we_nxt    = (rx_cmd == CMD_W'(CMD_WRITE));
                tmo_clr   = 1'b1;
                state_nxt = ST_ISSUE;
              end
            end
            default: tx_nxt = SPI_RX;
          endcase
        end
      end
      ST_ISSUE: begin
        if (bus.BUS_ACK) begin
          req_nxt   = 1'b0;
          tx_nxt    = {cmd_q, addr_q, we_q ? data_q : bus.BUS_RDATA};
          state_nxt = ST_RESP;
        end else if (tmo_exp) begin
          req_nxt   = 1'b0;
          tmo_nxt   = 1'b1;
          tx_nxt    = {cmd_q, addr_q, {DATA_W{1'b1}}};
          state_nxt = ST_RESP;
        end else begin
          tmo_en = 1'b1;
        end
      end
      ST_RESP: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase

    // A frame arriving mid-transaction is dropped; only the flag records it.
    if (frame_evt && state_q != ST_IDLE) ovr_nxt = 1'b1;
  end

  always_ff @(posedge CLK_SYS) begin
    if (!RSTN) begin
      state_q  <= ST_IDLE;
      drdy_dly <= 1'b0;
      cmd_q    <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      tx_q     <= '0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      fcnt_q   <= '0;
      ovr_q    <= 1'b0;
      tmo_q    <= 1'b0;
      ill_q    <= 1'b0;
    end else begin
      state_q  <= state_nxt;
      drdy_dly <= SPI_DRDY;
      cmd_q    <= cmd_nxt;
      addr_q   <= addr_nxt;
      data_q   <= data_nxt;
      tx_q     <= tx_nxt;
      req_q    <= req_nxt;
      we_q     <= we_nxt;
      fcnt_q   <= fcnt_nxt;
      ovr_q    <= ovr_nxt;
      tmo_q    <= tmo_nxt;
      ill_q    <= ill_nxt;
    end
  end

  assign SPI_TX        = tx_q;
  assign BUSY          = (state_q != ST_IDLE);
  assign bus.BUS_REQ   = req_q;
  assign bus.BUS_WE    = we_q;
  assign bus.BUS_ADDR  = addr_q;
  assign bus.BUS_WDATA = data_q;
endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// Directed bench for spi_cmd_ctrl: bus write/read, timeout, reserved address,
// overrun, STATUS flag clearing, mid-transaction reset and counter wrap.
module tb_spi_cmd_ctrl;
  logic        clk;
  logic        rstn;
  logic        drdy;
  logic [19:0] rx;
  logic [19:0] tx;
  logic        busy;
  int          n_chk;
  int          n_pass;
  int          hi;

  spi_cmd_ctrl_if #(.ADDR_W(6), .DATA_W(12)) bif ();

  spi_cmd_ctrl dut (
    .CLK_SYS  (clk),
    .RSTN     (rstn),
    .SPI_DRDY (drdy),
    .SPI_RX   (rx),
    .SPI_TX   (tx),
    .BUSY     (busy),
    .bus      (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // One DRDY pulse; returns one edge after the DUT sampled the frame.
  task automatic send_frame(input logic [19:0] word);
    rx   = word;
    drdy = 1'b1;
    tick();
    drdy = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 200) begin
      tick();
      n++;
    end
    check(tag, busy, 1'b0);
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    rstn   = 1'b0;
    drdy   = 1'b0;
    rx     = '0;
    bif.BUS_ACK   = 1'b0;
    bif.BUS_RDATA = '0;
    repeat (3) tick();
    check("rst_tx",    tx,            20'h0);
    check("rst_req",   bif.BUS_REQ,   1'b0);
    check("rst_we",    bif.BUS_WE,    1'b0);
    check("rst_addr",  bif.BUS_ADDR,  6'd0);
    check("rst_wdata", bif.BUS_WDATA, 12'h0);
    check("rst_busy",  busy,          1'b0);
    rstn = 1'b1;
    tick();

    // WRITE addr 5 data 0xABC, ACK raised in the fourth REQ cycle
    send_frame(20'h45ABC);
    check("wr_req",   bif.BUS_REQ,   1'b1);
    check("wr_we",    bif.BUS_WE,    1'b1);
    check("wr_addr",  bif.BUS_ADDR,  6'd5);
    check("wr_wdata", bif.BUS_WDATA, 12'hABC);
    hi = int'(bif.BUS_REQ);
    repeat (3) begin
      tick();
      hi += int'(bif.BUS_REQ);
    end
    bif.BUS_ACK = 1'b1;
    tick();
    bif.BUS_ACK = 1'b0;
    check("wr_req_cycles", hi, 4);
    check("wr_req_drop",   bif.BUS_REQ, 1'b0);
    check("wr_tx",         tx, 20'h45ABC);
    wait_idle("wr_idle");

    send_frame(20'hC0000);
    check("st_cnt1", tx, 20'hC0001);
    wait_idle("st1_idle");

    // READ addr 7, immediate ACK with 0x123
    send_frame(20'h87000);
    check("rd_we",   bif.BUS_WE,   1'b0);
    check("rd_addr", bif.BUS_ADDR, 6'd7);
    bif.BUS_ACK   = 1'b1;
    bif.BUS_RDATA = 12'h123;
    tick();
    bif.BUS_ACK   = 1'b0;
    bif.BUS_RDATA = 12'h000;
    check("rd_tx", tx, 20'h87123);
    wait_idle("rd_idle");

    // READ addr 2 with no ACK: REQ held for TIMEOUT cycles
    send_frame(20'h82000);
    hi = 0;
    while (bif.BUS_REQ && hi < 200) begin
      hi++;
      tick();
    end
    check("to_req_cycles", hi, 64);
    check("to_tx", tx, 20'h82FFF);
    wait_idle("to_idle");

    send_frame(20'hC0000);
    check("st_timeout_set", tx, 20'hC0404);
    wait_idle("st2_idle");
    send_frame(20'hC0000);
    check("st_timeout_clr", tx, 20'hC0005);
    wait_idle("st3_idle");

    // WRITE to reserved addr 61: no bus cycle
    send_frame(20'h7D000);
    check("ill_req0", bif.BUS_REQ, 1'b0);
    check("ill_tx",   tx, 20'h7DFFF);
    tick();
    check("ill_req1", bif.BUS_REQ, 1'b0);
    wait_idle("ill_idle");
    send_frame(20'hC0000);
    check("st_ill", tx, 20'hC0207);
    wait_idle("st4_idle");

    // Overrun: NOP frame arrives while a WRITE to addr 3 is in flight
    send_frame(20'h43055);
    tick();
    send_frame(20'h00000);
    check("ovr_req_held", bif.BUS_REQ, 1'b1);
    bif.BUS_ACK = 1'b1;
    tick();
    bif.BUS_ACK = 1'b0;
    check("ovr_tx", tx, 20'h43055);
    wait_idle("ovr_idle");
    send_frame(20'hC0000);
    check("st_ovr", tx, 20'hC0809);
    wait_idle("st5_idle");

    send_frame(20'h12345);
    check("nop_echo", tx, 20'h12345);
    wait_idle("nop_idle");

    // Reset while a READ is outstanding
    send_frame(20'h81000);
    check("rr_req_pre", bif.BUS_REQ, 1'b1);
    rstn = 1'b0;
    tick();
    check("rr_req",   bif.BUS_REQ,   1'b0);
    check("rr_tx",    tx,            20'h0);
    check("rr_busy",  busy,          1'b0);
    check("rr_we",    bif.BUS_WE,    1'b0);
    check("rr_addr",  bif.BUS_ADDR,  6'd0);
    check("rr_wdata", bif.BUS_WDATA, 12'h0);
    rstn = 1'b1;
    tick();

    // 256 NOPs wrap the frame counter back to zero
    for (int i = 0; i < 256; i++) begin
      send_frame(20'h00001);
      tick();
    end
    check("wrap_busy", busy, 1'b0);
    send_frame(20'hC0000);
    check("st_wrap", tx, 20'hC0000);
    wait_idle("wrap_idle");
    send_frame(20'hC0000);
    check("st_after_wrap", tx, 20'hC0001);
    wait_idle("end_idle");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
